delay_arbiter: RTL and testbench



---
 rtl/delay_arbiter.sv | 151 +++++++++++++++
 tb/tb_delay_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay timer between NREQ requesters.
// Optional watchdog abort enabled by defining DELAY_ARB_WDOG_EN.
module delay_arbiter #(
  parameter int NREQ        = 4,
  parameter int WDOG_CYCLES = 4200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] sel_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic              busy_o,
  output logic              tmr_enable_o,
  output logic [1:0]        tmr_x_o,
  input  logic              tmr_ready_i,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshake: req_i is a level held by the requester until done_o or withdrawal;
  // the owner sees done_o for one cycle and must drop req_i on the following edge.
  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic            r_en;
  logic [1:0]      r_x;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;
  logic [1:0]      w_sel;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_sel   = 2'b00;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
        w_sel   = sel_i[{w_idx, 1'b0} +: 2];
      end
    end
  end

`ifdef DELAY_ARB_WDOG_EN
  localparam int CW = ($clog2(WDOG_CYCLES) > 23) ? $clog2(WDOG_CYCLES) : 23;
  logic [CW-1:0] r_cnt;
  logic          r_err;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= IW'(NREQ - 1);
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_x     <= 2'b00;
`ifdef DELAY_ARB_WDOG_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= '0;
`ifdef DELAY_ARB_WDOG_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_WAIT;
            r_grant <= NREQ'(1) << w_win;
            r_x     <= w_sel;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_ptr   <= w_win;
`ifdef DELAY_ARB_WDOG_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // Ready takes priority over both withdrawal and the watchdog.
          if (tmr_ready_i) begin
            r_state <= ST_DONE;
            r_done  <= r_grant;
            r_en    <= 1'b0;
          end else if ((req_i & r_grant) == '0) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
`ifdef DELAY_ARB_WDOG_EN
          else if (r_cnt == CW'(WDOG_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o      = r_grant;
  assign done_o       = r_done;
  assign busy_o       = r_busy;
  assign tmr_enable_o = r_en;
  assign tmr_x_o      = r_x;
  assign dbg_state_o  = r_state;

`ifdef DELAY_ARB_WDOG_EN
  assign err_o = r_err;
`else
  // No watchdog: the limit only participates in a constant-false term.
  assign err_o = 1'b0 && (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: vector table, corner-case sequences and a done_o scoreboard.
// Watchdog expectations follow DELAY_ARB_WDOG_EN with WDOG_CYCLES=100.
module tb_delay_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] sel;
  logic              rdy;
  logic [NREQ-1:0]   grant_o;
  logic [NREQ-1:0]   done_o;
  logic              busy_o;
  logic              tmr_enable_o;
  logic [1:0]        tmr_x_o;
  logic              err_o;
  logic [1:0]        dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] sb_exp;
  logic            seen_err;

  delay_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req),
    .sel_i        (sel),
    .grant_o      (grant_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .tmr_enable_o (tmr_enable_o),
    .tmr_x_o      (tmr_x_o),
    .tmr_ready_i  (rdy),
    .err_o        (err_o),
    .dbg_state_o  (dbg_state_o)
  );

  always #25 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    rdy   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (grant_o == '0 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(grant_o != '0), 32'd1);
  endtask

  // Scoreboard: every done_o pulse must match the oldest expected owner.
  always @(negedge clk) begin
    if (!reset && done_o != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_unexpected actual=%0h expected=none", done_o);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("done_sb", 32'(done_o), 32'(sb_exp));
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] req;
    logic            rdy;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    logic            en;
    logic [1:0]      x;
    logic            busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1ms;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    rdy   = 1'b0;
    sel   = 8'b11_10_01_00;
    tick();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_en", 32'(tmr_enable_o), 0);
    reset = 1'b0;
    tick();
    chk("idle_grant", 32'(grant_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_en", 32'(tmr_enable_o), 0);
    chk("idle_x", 32'(tmr_x_o), 0);
    chk("idle_err", 32'(err_o), 0);

    //              req      rdy   grant    done     en    x      busy
    vecs[0]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'b01, 1'b1};
    vecs[1]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'b01, 1'b1};
    vecs[2]  = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'b01, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b01, 1'b0};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'b01, 1'b0};
    vecs[5]  = '{4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'b11, 1'b1};
    vecs[6]  = '{4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'b11, 1'b1};
    vecs[7]  = '{4'b1010, 1'b1, 4'b1000, 4'b1000, 1'b0, 2'b11, 1'b1};
    vecs[8]  = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'b11, 1'b0};
    vecs[9]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'b01, 1'b1};
    vecs[10] = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'b01, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b01, 1'b0};

    for (int i = 0; i < 12; i++) begin
      req = vecs[i].req;
      rdy = vecs[i].rdy;
      if (vecs[i].d != '0) exp_q.push_back(vecs[i].d);
      tick();
      chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vecs[i].g));
      chk($sformatf("v%0d_done", i), 32'(done_o), 32'(vecs[i].d));
      chk($sformatf("v%0d_en", i), 32'(tmr_enable_o), 32'(vecs[i].en));
      chk($sformatf("v%0d_x", i), 32'(tmr_x_o), 32'(vecs[i].x));
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
    end
    rdy = 1'b0;

    // Single request with a 50-cycle delay, then enable low for two cycles.
    req = 4'b0010;
    tick();
    chk("single_grant", 32'(grant_o), 32'h2);
    chk("single_x", 32'(tmr_x_o), 32'h1);
    chk("single_en", 32'(tmr_enable_o), 1);
    repeat (49) tick();
    chk("single_en_hold", 32'(tmr_enable_o), 1);
    exp_q.push_back(4'b0010);
    rdy = 1'b1;
    tick();
    chk("single_done", 32'(done_o), 32'h2);
    rdy = 1'b0;
    req = '0;
    tick();
    chk("single_done_off", 32'(done_o), 0);
    chk("single_en_low1", 32'(tmr_enable_o), 0);
    tick();
    chk("single_en_low2", 32'(tmr_enable_o), 0);

    // Select stability: owner changes its select during WAIT.
    req = 4'b0001;
    tick();
    chk("sel_grant", 32'(grant_o), 32'h1);
    chk("sel_x0", 32'(tmr_x_o), 0);
    sel = 8'b11_10_01_11;
    tick();
    chk("sel_x1", 32'(tmr_x_o), 0);
    tick();
    chk("sel_x2", 32'(tmr_x_o), 0);
    exp_q.push_back(4'b0001);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    req = '0;
    sel = 8'b11_10_01_00;
    tick();

    // Round-robin from reset, two full rounds.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
        wait_grant("rr");
        chk($sformatf("rr%0d_grant%0d", r, i), 32'(grant_o), 32'(1) << i);
        exp_q.push_back(NREQ'(1) << i);
        tick();
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        req = req & ~(NREQ'(1) << i);
        tick();
      end
    end

    // Withdrawal of owner 2 with requester 3 pending.
    req = 4'b1100;
    tick();
    chk("wd_grant", 32'(grant_o), 32'h4);
    tick();
    req = 4'b1000;
    tick();
    chk("abort_grant", 32'(grant_o), 0);
    chk("abort_en", 32'(tmr_enable_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_done", 32'(done_o), 0);
    tick();
    chk("next_grant", 32'(grant_o), 32'h8);
    chk("next_en", 32'(tmr_enable_o), 1);
    chk("next_x", 32'(tmr_x_o), 32'h3);
    exp_q.push_back(4'b1000);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    req = '0;
    tick();

    // Ready and withdrawal together: ready wins.
    req = 4'b0001;
    tick();
    chk("col_grant", 32'(grant_o), 32'h1);
    tick();
    exp_q.push_back(4'b0001);
    req = '0;
    rdy = 1'b1;
    tick();
    chk("col_done", 32'(done_o), 32'h1);
    chk("col_en", 32'(tmr_enable_o), 0);
    rdy = 1'b0;
    tick();
    chk("col_idle", 32'(grant_o), 0);

    // Asynchronous reset in the middle of WAIT.
    req = 4'b0110;
    tick();
    chk("mr_grant", 32'(grant_o), 32'h2);
    tick();
    #10;
    reset = 1'b1;
    #1;
    chk("mr_grant0", 32'(grant_o), 0);
    chk("mr_en0", 32'(tmr_enable_o), 0);
    chk("mr_busy0", 32'(busy_o), 0);
    chk("mr_x0", 32'(tmr_x_o), 0);
    chk("mr_err0", 32'(err_o), 0);
    req = 4'b0110;
    tick();
    #10;
    reset = 1'b0;
    tick();
    chk("mr_ptr", 32'(grant_o), 32'h2);
    req = '0;
    tick();
    tick();

    // Watchdog behaviour.
    req = 4'b0001;
    tick();
    chk("wdog_grant", 32'(grant_o), 32'h1);
    seen_err = 1'b0;
`ifdef DELAY_ARB_WDOG_EN
    repeat (99) begin
      tick();
      seen_err = seen_err | err_o;
    end
    chk("wdog_early", 32'(seen_err), 0);
    chk("wdog_en_before", 32'(tmr_enable_o), 1);
    tick();
    chk("wdog_err", 32'(err_o), 1);
    chk("wdog_grant0", 32'(grant_o), 0);
    chk("wdog_en0", 32'(tmr_enable_o), 0);
    tick();
    chk("wdog_err_pulse", 32'(err_o), 0);
    req = '0;
    tick();
`else
    repeat (150) begin
      tick();
      seen_err = seen_err | err_o;
    end
    chk("nowdog_err", 32'(seen_err), 0);
    chk("nowdog_en", 32'(tmr_enable_o), 1);
    chk("nowdog_grant", 32'(grant_o), 32'h1);
    req = '0;
    tick();
    tick();
`endif

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
